// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle: clear control, two pixel-write requesters
// and the registered bRAM port-A strobes.
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;

  logic              r0_valid;
  logic              r0_ready;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_data;

  logic              r1_valid;
  logic              r1_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              mem_en;
  logic              drop;

  // Requester / controller side
  modport master (
    output clr_start, clr_color,
    output r0_valid, r0_addr, r0_data,
    output r1_valid, r1_addr, r1_data,
    input  clr_busy, clr_done, r0_ready, r1_ready,
    input  mem_addr, mem_din, mem_we, mem_en, drop
  );

  // Arbiter side
  modport slave (
    input  clr_start, clr_color,
    input  r0_valid, r0_addr, r0_data,
    input  r1_valid, r1_addr, r1_data,
    output clr_busy, clr_done, r0_ready, r1_ready,
    output mem_addr, mem_din, mem_we, mem_en, drop
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of framebuffer bRAM port A with a built-in clear
// sequencer. All port-A strobes are registered (1-cycle latency).
module fb_write_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int FB_WORDS = 307200
) (
  input  logic               clk,
  input  logic               rstn,
  fb_write_arbiter_if.slave  bus
);

  localparam int                CNT_W    = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FB_WORDS - 1);
  localparam logic [ADDR_W:0]   FB_LIM   = (ADDR_W + 1)'(FB_WORDS);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              rr_last, rr_last_nxt;
  logic [DATA_W-1:0] color_q;

  logic              gnt0, gnt1;

  // p0: next values of the port-A strobes; p1: registered strobes on the pins
  logic [ADDR_W-1:0] addr_p0, addr_p1;
  logic [DATA_W-1:0] din_p0, din_p1;
  logic              vld_p0, vld_p1;
  logic              busy_p0, busy_p1;
  logic              done_p0, done_p1;
  logic              drop_p0, drop_p1;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= FB_LIM);
  endfunction

  // State register: FSM state, clear counter, round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ARB;
      cnt     <= '0;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // Clear colour is captured only when a clear is launched from ARB
  always_ff @(posedge clk) begin
    if (state == ARB && bus.clr_start) color_q <= bus.clr_color;
  end

  // Next-state: launch/finish clear, advance counter, update round-robin
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rr_last_nxt = rr_last;
    case (state)
      ARB: begin
        if (bus.clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (gnt0) begin
          rr_last_nxt = 1'b0;
        end else if (gnt1) begin
          rr_last_nxt = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt == CNT_LAST) state_nxt = ARB;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ARB;
    endcase
  end

  // Outputs: combinational grants and next values of the registered strobes
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    addr_p0 = addr_p1;
    din_p0  = din_p1;
    vld_p0  = 1'b0;
    busy_p0 = 1'b0;
    done_p0 = 1'b0;
    drop_p0 = 1'b0;
    case (state)
      ARB: begin
        if (bus.clr_start) begin
          addr_p0 = '0;
          din_p0  = bus.clr_color;
          vld_p0  = 1'b1;
          busy_p0 = 1'b1;
        end else begin
          gnt0 = bus.r0_valid & (~bus.r1_valid | rr_last);
          gnt1 = bus.r1_valid & (~bus.r0_valid | ~rr_last);
          if (gnt0) begin
            if (out_of_range(bus.r0_addr)) begin
              drop_p0 = 1'b1;
            end else begin
              addr_p0 = bus.r0_addr;
              din_p0  = bus.r0_data;
              vld_p0  = 1'b1;
            end
          end else if (gnt1) begin
            if (out_of_range(bus.r1_addr)) begin
              drop_p0 = 1'b1;
            end else begin
              addr_p0 = bus.r1_addr;
              din_p0  = bus.r1_data;
              vld_p0  = 1'b1;
            end
          end
        end
      end
      CLEAR: begin
        if (cnt == CNT_LAST) begin
          done_p0 = 1'b1;
        end else begin
          addr_p0 = ADDR_W'(cnt + 1'b1);
          din_p0  = color_q;
          vld_p0  = 1'b1;
          busy_p0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---- stage p0 -> p1: registered port-A strobes and status pulses ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_p1 <= '0;
      din_p1  <= '0;
      vld_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
      drop_p1 <= 1'b0;
    end else begin
      addr_p1 <= addr_p0;
      din_p1  <= din_p0;
      vld_p1  <= vld_p0;
      busy_p1 <= busy_p0;
      done_p1 <= done_p0;
      drop_p1 <= drop_p0;
    end
  end

  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;
  assign bus.mem_addr = addr_p1;
  assign bus.mem_din  = din_p1;
  assign bus.mem_we   = vld_p1;
  assign bus.mem_en   = vld_p1;
  assign bus.clr_busy = busy_p1;
  assign bus.clr_done = done_p1;
  assign bus.drop     = drop_p1;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter (FB_WORDS=16) with a write scoreboard.
module tb_fb_write_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  typedef struct packed {
    logic          drp;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  fb_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(NW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic drp, input logic [AW-1:0] a, input logic [DW-1:0] d);
    q.push_back('{drp: drp, addr: a, data: d});
  endtask

  // Scoreboard: every write or drop seen on port A must match the next expected item
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1) begin
      chk("en_eq_we", bus.mem_en, bus.mem_we);
      if (bus.mem_we || bus.drop) begin
        chk("sb_nonempty", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sb_drop", bus.drop, e.drp);
          chk("sb_we", bus.mem_we, !e.drp);
          if (!e.drp) begin
            chk("sb_addr", bus.mem_addr, e.addr);
            chk("sb_data", bus.mem_din, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn          = 1'b0;
    bus.clr_start = 1'b0;
    bus.clr_color = '0;
    bus.r0_valid  = 1'b0;
    bus.r0_addr   = '0;
    bus.r0_data   = '0;
    bus.r1_valid  = 1'b0;
    bus.r1_addr   = '0;
    bus.r1_data   = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_we", bus.mem_we, 0);
    chk("rst_en", bus.mem_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_din", bus.mem_din, 0);
    chk("rst_busy", bus.clr_busy, 0);
    chk("rst_done", bus.clr_done, 0);
    chk("rst_drop", bus.drop, 0);
    rstn = 1'b1;
    tick();

    // 1: lone r0 write, 1-cycle latency
    bus.r0_valid = 1'b1; bus.r0_addr = 19'd5; bus.r0_data = 16'hABCD;
    #1;
    chk("t1_r0_ready", bus.r0_ready, 1);
    chk("t1_r1_ready", bus.r1_ready, 0);
    push(1'b0, 19'd5, 16'hABCD);
    tick();
    bus.r0_valid = 1'b0;
    chk("t1_we", bus.mem_we, 1);
    chk("t1_addr", bus.mem_addr, 5);
    chk("t1_din", bus.mem_din, 16'hABCD);
    tick();
    chk("t1_idle_we", bus.mem_we, 0);
    chk("t1_hold_addr", bus.mem_addr, 5);

    // lone r1 write so r0 holds priority next
    bus.r1_valid = 1'b1; bus.r1_addr = 19'd2; bus.r1_data = 16'h2222;
    #1;
    chk("t1b_r1_ready", bus.r1_ready, 1);
    push(1'b0, 19'd2, 16'h2222);
    tick();
    bus.r1_valid = 1'b0;
    tick();

    // 2: both valid for 4 cycles -> r0,r1,r0,r1
    bus.r0_valid = 1'b1; bus.r0_addr = 19'd1; bus.r0_data = 16'h1111;
    bus.r1_valid = 1'b1; bus.r1_addr = 19'd2; bus.r1_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_r0_ready", bus.r0_ready, (i % 2 == 0));
      chk("t2_r1_ready", bus.r1_ready, (i % 2 == 1));
      if (i % 2 == 0) push(1'b0, 19'd1, 16'h1111);
      else            push(1'b0, 19'd2, 16'h2222);
      tick();
      chk("t2_we", bus.mem_we, 1);
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    tick();

    // 3: clear while r1 pending; r1 accepted in the clr_done cycle
    bus.r1_valid = 1'b1; bus.r1_addr = 19'd9; bus.r1_data = 16'h9999;
    bus.clr_start = 1'b1; bus.clr_color = 16'h0F0F;
    #1;
    chk("t3_r1_ready_start", bus.r1_ready, 0);
    chk("t3_r0_ready_start", bus.r0_ready, 0);
    for (int i = 0; i < NW; i++) push(1'b0, AW'(i), 16'h0F0F);
    push(1'b0, 19'd9, 16'h9999);
    tick();
    bus.clr_start = 1'b0; bus.clr_color = 16'h0000;
    for (int i = 0; i < NW; i++) begin
      chk("t3_busy", bus.clr_busy, 1);
      chk("t3_we", bus.mem_we, 1);
      chk("t3_addr", bus.mem_addr, i);
      chk("t3_r1_ready", bus.r1_ready, 0);
      tick();
    end
    chk("t3_done", bus.clr_done, 1);
    chk("t3_busy_end", bus.clr_busy, 0);
    chk("t3_we_end", bus.mem_we, 0);
    chk("t3_r1_ready_done", bus.r1_ready, 1);
    tick();
    bus.r1_valid = 1'b0;
    chk("t3_done_pulse", bus.clr_done, 0);
    chk("t3_r1_write", bus.mem_we, 1);
    tick();

    // 4: out-of-range write is accepted then dropped; last valid address accepted
    bus.r0_valid = 1'b1; bus.r0_addr = 19'd16; bus.r0_data = 16'h1234;
    #1;
    chk("t4_r0_ready", bus.r0_ready, 1);
    push(1'b1, 19'd16, 16'h1234);
    tick();
    chk("t4_we", bus.mem_we, 0);
    chk("t4_drop", bus.drop, 1);
    bus.r0_addr = 19'd15; bus.r0_data = 16'h4321;
    push(1'b0, 19'd15, 16'h4321);
    tick();
    bus.r0_valid = 1'b0;
    chk("t4_edge_we", bus.mem_we, 1);
    chk("t4_edge_drop", bus.drop, 0);
    tick();

    // 6: second clr_start mid-clear is ignored
    bus.clr_start = 1'b1; bus.clr_color = 16'h00FF;
    for (int i = 0; i < NW; i++) push(1'b0, AW'(i), 16'h00FF);
    tick();
    bus.clr_start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (i == 3) begin bus.clr_start = 1'b1; bus.clr_color = 16'hFFFF; end
      if (i == 4) bus.clr_start = 1'b0;
      chk("t6_busy", bus.clr_busy, 1);
      tick();
    end
    chk("t6_done", bus.clr_done, 1);
    tick();
    chk("t6_no_restart_we", bus.mem_we, 0);
    chk("t6_no_restart_busy", bus.clr_busy, 0);
    repeat (3) tick();

    // 5: reset mid-clear at cnt=7 aborts with no done and restores r0 priority
    bus.clr_start = 1'b1; bus.clr_color = 16'h5555;
    for (int i = 0; i < NW; i++) push(1'b0, AW'(i), 16'h5555);
    tick();
    bus.clr_start = 1'b0;
    repeat (7) tick();
    chk("t5_cnt7", bus.mem_addr, 7);
    rstn = 1'b0;
    #1;
    chk("t5_rst_we", bus.mem_we, 0);
    chk("t5_rst_addr", bus.mem_addr, 0);
    chk("t5_rst_din", bus.mem_din, 0);
    chk("t5_rst_busy", bus.clr_busy, 0);
    q.delete();
    repeat (2) tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_no_done", bus.clr_done, 0);
      chk("t5_no_strobe", bus.mem_we, 0);
    end
    bus.r0_valid = 1'b1; bus.r0_addr = 19'd3; bus.r0_data = 16'h3333;
    bus.r1_valid = 1'b1; bus.r1_addr = 19'd4; bus.r1_data = 16'h4444;
    #1;
    chk("t5_r0_prio", bus.r0_ready, 1);
    chk("t5_r1_wait", bus.r1_ready, 0);
    push(1'b0, 19'd3, 16'h3333);
    tick();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    repeat (2) tick();

    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
